// File: rtl/alu_issue_ctrl.sv
// Multi-pass issue controller for RISC-V OP/OP-IMM ops onto a 3-bit-op combinational ALU.
// Optional build macro ALU_ISSUE_PERF_EN adds perf_ops/perf_busy counters.
module alu_issue_ctrl #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            is_imm,
  input  logic [2:0]      funct3,
  input  logic            funct7_5,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [XLEN-1:0] imm_val,
  output logic [XLEN-1:0] alu_in0,
  output logic [XLEN-1:0] alu_in1,
  output logic [2:0]      alu_op,
  input  logic [XLEN-1:0] alu_res,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
`ifdef ALU_ISSUE_PERF_EN
  output logic [31:0]     perf_ops,
  output logic [31:0]     perf_busy,
`endif
  output logic            illegal
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [XLEN-1:0]      a_q, b_q, t1_q, t2_q, result_q, res_d;
  logic [2:0]           f3_q;
  logic                 f7_q, imm_q, illegal_q;
  logic [SHAMT_W-1:0]   step_q, shamt;
  logic                 is_ill, is_shift, last;

  assign shamt    = b_q[SHAMT_W-1:0];
  assign is_shift = (f3_q == 3'b001) || (f3_q == 3'b101);
  assign is_ill   = (f7_q && !imm_q && (f3_q != 3'b000) && (f3_q != 3'b101)) ||
                    (imm_q && (f3_q == 3'b001) && f7_q);

  always_comb begin
    last = 1'b1;
    if (!is_ill) begin
      if (f3_q == 3'b100)
        last = (step_q == SHAMT_W'(3));
      else if (is_shift)
        last = (shamt == '0) || (step_q == shamt - SHAMT_W'(1));
    end
  end

  // ALU drive; zero outside EXEC, for illegal ops and for zero-length shifts
  always_comb begin
    alu_in0 = '0;
    alu_in1 = '0;
    alu_op  = 3'd0;
    if (state_q == S_EXEC && !is_ill) begin
      case (f3_q)
        3'b000: begin alu_in0 = a_q; alu_in1 = b_q; alu_op = (f7_q && !imm_q) ? 3'd3 : 3'd2; end
        3'b111: begin alu_in0 = a_q; alu_in1 = b_q; alu_op = 3'd0; end
        3'b110: begin alu_in0 = a_q; alu_in1 = b_q; alu_op = 3'd1; end
        3'b010, 3'b011: begin alu_in0 = a_q; alu_in1 = b_q; alu_op = 3'd3; end
        3'b100: begin
          case (step_q)
            SHAMT_W'(0): begin alu_in0 = a_q;  alu_in1 = b_q;  alu_op = 3'd0; end
            SHAMT_W'(1): begin alu_in0 = t1_q; alu_in1 = t1_q; alu_op = 3'd5; end
            SHAMT_W'(2): begin alu_in0 = a_q;  alu_in1 = b_q;  alu_op = 3'd1; end
            default:     begin alu_in0 = t1_q; alu_in1 = t2_q; alu_op = 3'd0; end
          endcase
        end
        default: begin
          if (shamt != '0) begin
            alu_in0 = (step_q == '0) ? a_q : t1_q;
            alu_op  = (f3_q == 3'b001) ? 3'd7 : (f7_q ? 3'd4 : 3'd6);
          end
        end
      endcase
    end
  end

  // SLT/SLTU: on differing signs the operand signs decide, else the SUB sign does
  always_comb begin
    res_d = alu_res;
    if (is_ill)
      res_d = '0;
    else if (f3_q == 3'b010)
      res_d = {{(XLEN-1){1'b0}}, (a_q[XLEN-1] != b_q[XLEN-1]) ? a_q[XLEN-1] : alu_res[XLEN-1]};
    else if (f3_q == 3'b011)
      res_d = {{(XLEN-1){1'b0}}, (a_q[XLEN-1] != b_q[XLEN-1]) ? b_q[XLEN-1] : alu_res[XLEN-1]};
    else if (is_shift && shamt == '0)
      res_d = a_q;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid) state_d = S_EXEC;
      S_EXEC:  if (last) state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      t1_q      <= '0;
      t2_q      <= '0;
      f3_q      <= '0;
      f7_q      <= 1'b0;
      imm_q     <= 1'b0;
      step_q    <= '0;
      result_q  <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: if (in_valid) begin
          a_q    <= rs1_val;
          b_q    <= is_imm ? imm_val : rs2_val;
          f3_q   <= funct3;
          f7_q   <= funct7_5;
          imm_q  <= is_imm;
          step_q <= '0;
        end
        S_EXEC: begin
          step_q <= step_q + SHAMT_W'(1);
          // t2 keeps the NOR term; t1 holds the AND, then OR, or the running shift value
          if (f3_q == 3'b100 && step_q == SHAMT_W'(1)) t2_q <= alu_res;
          else                                         t1_q <= alu_res;
          if (last) begin
            result_q  <= res_d;
            illegal_q <= is_ill;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign result    = result_q;
  assign illegal   = illegal_q;

`ifdef ALU_ISSUE_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_ops  <= '0;
      perf_busy <= '0;
    end else begin
      if (state_q == S_DONE && out_ready) perf_ops <= perf_ops + 32'd1;
      if (state_q != S_IDLE)              perf_busy <= perf_busy + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU model closing the loop.
module tb_alu_issue_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, is_imm, funct7_5;
  logic [2:0]  funct3;
  logic [31:0] rs1_val, rs2_val, imm_val;
  logic [31:0] alu_in0, alu_in1, alu_res;
  logic [2:0]  alu_op;
  logic        out_valid, out_ready, illegal;
  logic [31:0] result;

  int checks = 0;
  int failures = 0;
  logic [2:0] ops_log [0:31];
  int cyc;

  always #5 clk = ~clk;

  alu_issue_ctrl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .is_imm(is_imm), .funct3(funct3), .funct7_5(funct7_5),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .imm_val(imm_val),
    .alu_in0(alu_in0), .alu_in1(alu_in1), .alu_op(alu_op), .alu_res(alu_res),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .illegal(illegal)
  );

  always_comb begin
    case (alu_op)
      3'd0: alu_res = alu_in0 & alu_in1;
      3'd1: alu_res = alu_in0 | alu_in1;
      3'd2: alu_res = alu_in0 + alu_in1;
      3'd3: alu_res = alu_in0 - alu_in1;
      3'd4: alu_res = {alu_in0[31], alu_in0[31:1]};
      3'd5: alu_res = ~(alu_in0 | alu_in1);
      3'd6: alu_res = {1'b0, alu_in0[31:1]};
      default: alu_res = {alu_in0[30:0], 1'b0};
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Accepts one request, logs alu_op per EXEC cycle, returns EXEC cycle count
  task automatic issue(input logic imm, input logic [2:0] f3, input logic f7,
                       input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] im,
                       output int n);
    @(negedge clk);
    is_imm = imm; funct3 = f3; funct7_5 = f7;
    rs1_val = r1; rs2_val = r2; imm_val = im; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 64) begin
      if (n < 32) ops_log[n] = alu_op;
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic retire();
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; is_imm = 1'b0;
    funct3 = 3'd0; funct7_5 = 1'b0; rs1_val = '0; rs2_val = '0; imm_val = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
    check("rst_alu_op", 32'(alu_op), 32'd0);
    check("rst_alu_in0", alu_in0, 32'd0);
    @(negedge clk); rst = 1'b0;

    // SUB 5-7
    issue(1'b0, 3'b000, 1'b1, 32'd5, 32'd7, 32'd0, cyc);
    check("sub_cyc", 32'(cyc), 32'd1);
    check("sub_op", 32'(ops_log[0]), 32'd3);
    check("sub_res", result, 32'hFFFF_FFFE);
    check("sub_ill", 32'(illegal), 32'd0);
    retire();
    check("sub_idle", 32'(in_ready), 32'd1);

    // XOR
    issue(1'b0, 3'b100, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'd0, cyc);
    check("xor_cyc", 32'(cyc), 32'd4);
    check("xor_op0", 32'(ops_log[0]), 32'd0);
    check("xor_op1", 32'(ops_log[1]), 32'd5);
    check("xor_op2", 32'(ops_log[2]), 32'd1);
    check("xor_op3", 32'(ops_log[3]), 32'd0);
    check("xor_res", result, 32'h0FF0_0FF0);
    retire();

    // SRAI by 3
    issue(1'b1, 3'b101, 1'b1, 32'h8000_0010, 32'd0, 32'h0000_0403, cyc);
    check("srai_cyc", 32'(cyc), 32'd3);
    for (int i = 0; i < 3; i++) check("srai_op", 32'(ops_log[i]), 32'd4);
    check("srai_res", result, 32'hF000_0002);
    check("srai_ill", 32'(illegal), 32'd0);
    retire();

    // SLLI by 0
    issue(1'b1, 3'b001, 1'b0, 32'h1234_5678, 32'd0, 32'd0, cyc);
    check("slli0_cyc", 32'(cyc), 32'd1);
    check("slli0_op", 32'(ops_log[0]), 32'd0);
    check("slli0_res", result, 32'h1234_5678);
    retire();

    // SRL by 4 (register)
    issue(1'b0, 3'b101, 1'b0, 32'h8000_00F0, 32'd4, 32'd0, cyc);
    check("srl_cyc", 32'(cyc), 32'd4);
    check("srl_op", 32'(ops_log[0]), 32'd6);
    check("srl_res", result, 32'h0800_000F);
    retire();

    // SLT / SLTU
    issue(1'b0, 3'b010, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, cyc);
    check("slt_a_res", result, 32'd1);
    retire();
    issue(1'b0, 3'b011, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, cyc);
    check("sltu_a_res", result, 32'd0);
    retire();
    issue(1'b0, 3'b010, 1'b0, 32'h7FFF_FFFF, 32'h8000_0000, 32'd0, cyc);
    check("slt_b_res", result, 32'd0);
    retire();
    issue(1'b1, 3'b011, 1'b0, 32'h7FFF_FFFF, 32'd0, 32'h8000_0000, cyc);
    check("sltiu_b_res", result, 32'd1);
    check("sltiu_b_op", 32'(ops_log[0]), 32'd3);
    retire();

    // ADDI ignores bit 30
    issue(1'b1, 3'b000, 1'b1, 32'd10, 32'd0, 32'hFFFF_FFFF, cyc);
    check("addi_op", 32'(ops_log[0]), 32'd2);
    check("addi_res", result, 32'd9);
    retire();

    // Illegal R-type XOR with bit 30, then backpressure
    issue(1'b0, 3'b100, 1'b1, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0, cyc);
    check("ill_cyc", 32'(cyc), 32'd1);
    @(negedge clk);
    in_valid = 1'b1; funct3 = 3'b000; funct7_5 = 1'b0; rs1_val = 32'd1; rs2_val = 32'd1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_result", result, 32'd0);
      check("bp_illegal", 32'(illegal), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0; in_valid = 1'b0;
    check("bp_rel_in_ready", 32'(in_ready), 32'd1);
    check("bp_rel_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check("bp_no_accept", 32'(in_ready), 32'd1);

    // Reset mid-SLL by 20
    @(negedge clk);
    is_imm = 1'b0; funct3 = 3'b001; funct7_5 = 1'b0;
    rs1_val = 32'd1; rs2_val = 32'd20; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    check("sll_busy", 32'(in_ready), 32'd0);
    repeat (5) @(posedge clk);
    #1;
    check("sll_pass5_in0", alu_in0, 32'h0000_0020);
    check("sll_pass5_op", 32'(alu_op), 32'd7);
    rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_alu_op", 32'(alu_op), 32'd0);

    issue(1'b0, 3'b000, 1'b0, 32'd2, 32'd3, 32'd0, cyc);
    check("add_cyc", 32'(cyc), 32'd1);
    check("add_res", result, 32'd5);
    retire();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
